// File: rtl/prng_arbiter_pkg.sv
// Shared types and helpers for the PRNG round-robin arbiter.
package prng_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Width needed to hold a burst length of 0..max_burst.
  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // A zero length still delivers one word; oversized requests are capped.
  function automatic int clamp_len(input int len, input int max_burst);
    int res;
    res = len;
    if (len < 1) begin
      res = 1;
    end else if (len > max_burst) begin
      res = max_burst;
    end
    return res;
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Requester-side bus: requests, burst lengths, grant and word handshake.
import prng_arb_pkg::*;

interface prng_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = len_w(MAX_BURST)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rnd_valid;
  logic [WIDTH-1:0]         rnd_data;
  logic                     rnd_last;
  logic [NUM_REQ-1:0]       rnd_ready;

  // Arbiter side
  modport master (
    input  req, req_len, rnd_ready,
    output gnt, rnd_valid, rnd_data, rnd_last
  );

  // Requester side
  modport slave (
    output req, req_len, rnd_ready,
    input  gnt, rnd_valid, rnd_data, rnd_last
  );
endinterface

// File: rtl/prng_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_any
);
  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan from the pointer position and keep only the first hit.
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/prng_arbiter.sv
// Round-robin burst scheduler sharing one external PRNG between requesters.
// prng_en is asserted only in a transfer cycle so each word is consumed once.
module prng_arbiter
  import prng_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = len_w(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst,
  prng_arbiter_if.master    bus,
  output logic              prng_en,
  input  logic [WIDTH-1:0]  prng_num,
  output logic              busy
);
  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]   r_own, w_own_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [LEN_W-1:0]   w_len_sel;
  logic               w_xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  // One-hot pick to owner index, and that owner's raw burst length.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
    w_len_sel = bus.req_len[int'(w_pick_idx)*LEN_W +: LEN_W];
  end

  // State, owner, pointer and remaining-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_own   <= w_own_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and outputs; a transfer needs the owner's ready and no reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_own_nxt     = r_own;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_xfer        = (r_state == SERVE) && bus.rnd_ready[r_own] && !rst;
    prng_en       = w_xfer;
    busy          = (r_state == SERVE);
    bus.rnd_valid = (r_state == SERVE);
    bus.rnd_last  = (r_state == SERVE) && (r_cnt == LEN_W'(1));
    bus.gnt       = r_gnt;
    bus.rnd_data  = prng_num;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = SERVE;
          w_gnt_nxt   = w_pick;
          w_own_nxt   = w_pick_idx;
          w_ptr_nxt   = (int'(w_pick_idx) == NUM_REQ - 1) ? '0 : w_pick_idx + 1'b1;
          w_cnt_nxt   = LEN_W'(clamp_len(int'(w_len_sel), MAX_BURST));
        end
      end
      SERVE: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (!bus.req[r_own]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: behavioural model compared every cycle, plus
// directed literal expectations for reset, round-robin order, bursts,
// backpressure, abort, length clamping and a random uniqueness soak.
module tb_prng_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;
  localparam int MB = 8;
  localparam int LW = 4;
  localparam logic [15:0] SEED = 16'h5A3C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prng_en;
  logic          busy;
  logic [W-1:0]  prng_num;

  prng_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB), .LEN_W(LW)) bus ();

  prng_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .prng_en  (prng_en),
    .prng_num (prng_num),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // xorshift16 word generator used as the external PRNG
  function automatic logic [15:0] xs(input logic [15:0] x);
    logic [15:0] y;
    y = x ^ (x << 7);
    y = y ^ (y >> 9);
    y = y ^ (y << 8);
    return y;
  endfunction

  always @(posedge clk) begin
    if (rst) prng_num <= SEED;
    else if (prng_en) prng_num <= xs(prng_num);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model state
  int          m_own  = -1;
  int          m_left = 0;
  int          m_ptr  = 0;
  logic [15:0] m_word = SEED;

  // event logs taken from the DUT for directed checks
  int          g_own[$];
  int          g_cyc[$];
  int          en_cnt   = 0;
  int          xfer_cnt = 0;
  int          last_cnt = 0;
  int          last_at  = 0;
  int          done_cnt = 0;
  logic [15:0] words[$];
  logic [15:0] all_words[$];
  logic [NR-1:0] prev_gnt = '0;

  always @(negedge clk) begin : compare
    logic          e_valid;
    logic          e_xfer;
    logic [NR-1:0] e_gnt;
    int            o;
    int            l;
    bit            found;

    e_valid = (m_own >= 0);
    e_gnt   = '0;
    if (e_valid) e_gnt[m_own] = 1'b1;
    e_xfer  = e_valid && bus.rnd_ready[m_own] && !rst;

    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("rnd_valid", 32'(bus.rnd_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(e_valid));
    chk("rnd_last", 32'(bus.rnd_last), 32'(e_valid && (m_left == 1)));
    chk("prng_en", 32'(prng_en), 32'(e_xfer));
    if (e_valid) chk("rnd_data", 32'(bus.rnd_data), 32'(m_word));

    if (bus.gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NR; i++) if (bus.gnt[i]) g_own.push_back(i);
      g_cyc.push_back(cyc);
    end
    prev_gnt = bus.gnt;
    if (prng_en) en_cnt++;
    if (prng_en && bus.rnd_valid) begin
      xfer_cnt++;
      words.push_back(bus.rnd_data);
      all_words.push_back(bus.rnd_data);
      if (bus.rnd_last) begin
        last_cnt++;
        last_at = xfer_cnt;
        done_cnt++;
      end
    end

    if (rst) begin
      m_own  = -1;
      m_left = 0;
      m_ptr  = 0;
      m_word = SEED;
      all_words.delete();
    end else if (m_own < 0) begin
      found = 1'b0;
      for (int i = 0; i < NR; i++) begin
        o = (m_ptr + i) % NR;
        if (!found && bus.req[o]) begin
          found  = 1'b1;
          m_own  = o;
          l      = int'(bus.req_len[o*LW +: LW]);
          m_left = (l == 0) ? 1 : ((l > MB) ? MB : l);
          m_ptr  = (o + 1) % NR;
        end
      end
    end else if (e_xfer) begin
      m_word = xs(m_word);
      m_left--;
      if (m_left == 0) m_own = -1;
    end else if (!bus.req[m_own]) begin
      m_own = -1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_len(input int idx, input int len);
    bus.req_len[idx*LW +: LW] = LW'(len);
  endtask

  // Request one burst from idx and hold until its last word, then release.
  task automatic run_burst(input int idx, input int len, input bit toggle,
                           input string nm, output int nx);
    int t0;
    int c0;
    int start;
    t0    = xfer_cnt;
    c0    = done_cnt;
    start = cyc;
    g_own.delete();
    g_cyc.delete();
    set_len(idx, len);
    bus.req            = '0;
    bus.req[idx]       = 1'b1;
    bus.rnd_ready      = '0;
    bus.rnd_ready[idx] = 1'b1;
    for (int k = 0; k < 60 && done_cnt == c0; k++) begin
      tick(1);
      if (toggle) bus.rnd_ready[idx] = ~bus.rnd_ready[idx];
    end
    bus.req       = '0;
    bus.rnd_ready = '0;
    chk({nm, " done"}, 32'(done_cnt - c0), 32'd1);
    chk({nm, " grants"}, 32'(g_own.size()), 32'd1);
    if (g_own.size() > 0) begin
      chk({nm, " owner"}, 32'(g_own[0]), 32'(idx));
      chk({nm, " latency"}, 32'(g_cyc[0] - start), 32'd1);
    end
    nx = xfer_cnt - t0;
    tick(2);
  endtask

  initial begin
    int c;
    int e0;
    int nx;
    int t0;
    int dup;
    int mism;
    logic [15:0] w;

    bus.req       = '0;
    bus.req_len   = '0;
    bus.rnd_ready = '0;
    rst           = 1'b1;

    // reset with all requesters active
    @(posedge clk);
    #1;
    bus.req       = '1;
    for (int i = 0; i < NR; i++) set_len(i, 1);
    bus.rnd_ready = '1;
    tick(1);
    chk("rst gnt", 32'(bus.gnt), 32'd0);
    chk("rst valid", 32'(bus.rnd_valid), 32'd0);
    chk("rst prng_en", 32'(prng_en), 32'd0);
    tick(1);
    rst = 1'b0;
    c   = cyc;
    g_own.delete();
    g_cyc.delete();

    // round robin, len 1 each, always ready
    tick(12);
    bus.req = '0;
    tick(3);
    chk("rr grants", 32'(g_own.size() >= 5), 32'd1);
    if (g_own.size() >= 5) begin
      chk("rr first latency", 32'(g_cyc[0] - c), 32'd1);
      chk("rr own0", 32'(g_own[0]), 32'd0);
      chk("rr own1", 32'(g_own[1]), 32'd1);
      chk("rr own2", 32'(g_own[2]), 32'd2);
      chk("rr own3", 32'(g_own[3]), 32'd3);
      chk("rr own4", 32'(g_own[4]), 32'd0);
      for (int i = 1; i < 5; i++) chk("rr gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);
    end

    // single burst of 3 to requester 2
    e0 = en_cnt;
    t0 = xfer_cnt;
    c  = last_cnt;
    run_burst(2, 3, 1'b0, "single", nx);
    chk("single words", 32'(nx), 32'd3);
    chk("single prng_en", 32'(en_cnt - e0), 32'd3);
    chk("single last count", 32'(last_cnt - c), 32'd1);
    chk("single last pos", 32'(last_at - t0), 32'd3);

    // backpressure: ready toggles
    words.delete();
    e0 = en_cnt;
    run_burst(0, 4, 1'b1, "bp", nx);
    chk("bp words", 32'(nx), 32'd4);
    chk("bp prng_en", 32'(en_cnt - e0), 32'd4);
    dup = 0;
    for (int i = 0; i < words.size(); i++)
      for (int j = i + 1; j < words.size(); j++)
        if (words[i] == words[j]) dup++;
    chk("bp distinct", 32'(dup), 32'd0);

    // abort after 2 of 5 words
    e0 = en_cnt;
    set_len(1, 5);
    bus.req       = 4'b0010;
    bus.rnd_ready = 4'b0010;
    tick(3);
    bus.req       = '0;
    bus.rnd_ready = '0;
    tick(1);
    chk("abort valid", 32'(bus.rnd_valid), 32'd0);
    chk("abort gnt", 32'(bus.gnt), 32'd0);
    chk("abort prng_en", 32'(en_cnt - e0), 32'd2);
    tick(2);

    // length clamping
    run_burst(3, 0, 1'b0, "len0", nx);
    chk("len0 words", 32'(nx), 32'd1);
    run_burst(1, 15, 1'b0, "len15", nx);
    chk("len15 words", 32'(nx), 32'd8);

    // random soak
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 7) == 0) bus.req = NR'($urandom);
      bus.req_len   = (NR*LW)'($urandom);
      bus.rnd_ready = NR'($urandom);
      tick(1);
    end
    bus.req       = '0;
    bus.rnd_ready = '0;
    tick(3);
    chk("soak count", 32'(all_words.size()), 32'(en_cnt));
    chk("soak activity", 32'(all_words.size() > 100), 32'd1);
    mism = 0;
    w    = SEED;
    for (int i = 0; i < all_words.size(); i++) begin
      if (all_words[i] !== w) mism++;
      w = xs(w);
    end
    chk("soak sequence", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
